decode: RTL and testbench
=========================

// Module: decode
// PURPOSE
//  Decode stage feeding the execute stage: accepts fetched instruction words and owns the
//  16-entry register file (write port driven by writeback). Splits fields, reads operands,
//  interlocks RAW/WAW hazards with a busy scoreboard, and presents a registered
//  valid/stall bundle (opecode, immf, data_rd, data_rs, cc, imm_ex) to execute.
// PARAMETERS
//  LEN_OPECODE  7   opcode field width
//  LEN_IMMF     1   immediate-flag width
//  LEN_REG      32  register/data width
//  LEN_CC       4   condition-code field width
//  LEN_IMM_EX   32  sign-extended immediate width
//  LEN_INSN     32  instruction word width
//  NUM_REG      16  register count (4-bit address)
// PORTS
//  clk       in   1            clock, all state on posedge
//  rst       in   1            asynchronous active-low reset
//  valid_i   in   1            insn_i valid from fetch
//  insn_i    in   LEN_INSN     instruction word
//  stall_o   out  1            hold fetch (insn_i not consumed)
//  valid_o   out  1            output bundle valid to execute
//  stall_i   in   1            execute cannot accept
//  opecode   out  LEN_OPECODE  insn[31:25]
//  immf      out  LEN_IMMF     insn[24]
//  data_rd   out  LEN_REG      regfile[insn[23:20]]
//  data_rs   out  LEN_REG      regfile[insn[19:16]]
//  cc        out  LEN_CC       insn[15:12]
//  imm_ex    out  LEN_IMM_EX   sign-extended insn[11:0]
//  wb_we_i   in   1            writeback write enable
//  wb_addr_i in   4            writeback register address
//  wb_data_i in   LEN_REG      writeback data
//  halted_o  out  1            hlt decoded and issued
// BEHAVIOUR
//  Reset (rst low, async): valid_o=0, all data outputs 0, busy mask 0, halted_o=0, regfile 0.
//  Output bundle is a register: loads when stall_i=0, holds when stall_i=1. Latency 1 cycle.
//  Writes rd: 000_xxxx except cmp 000_0100; 001_0xxx; ld 001_1000. No write: st/j/ja
//   (001_1001..011), nop 111_1110, hlt 111_1111. Reads rd: all except nop/hlt. Reads rs: immf=0.
//  Regfile write-first: wb write to address being read this cycle returns wb_data_i.
//  busy_eff = busy & ~(wb_we_i ? onehot(wb_addr_i) : 0), applied combinationally.
//  hazard = valid_i & ~halted & (RAW: a read register busy_eff | WAW: writer with busy_eff[rd]).
//  stall_o = (valid_o & stall_i) | hazard | halted_o.
//  stall_i=0, valid_i=1, no hazard, not halted: issue -> valid_o<=1, fields loaded; if writer,
//   busy[rd]<=1 (set beats same-cycle wb clear of same address).
//  stall_i=0 and (hazard | ~valid_i | halted): bubble -> valid_o<=0, data outputs don't-care.
//  stall_i=1: no issue, no busy set; wb clears still applied.
//  hlt issue: halted_o<=1 next cycle (the hlt itself goes out with valid_o=1); afterwards only
//   bubbles, stall_o=1 until reset. nop issues normally, sets no busy bit.
//  Regfile writes occur whenever wb_we_i=1, independent of stalls/halt.
//  Reset mid-hazard or mid-stall: all pending state cleared; no instruction issues.
// TESTING
//  1 Reset, wb r2=5 r3=7, insn add r2,r3 (0000000,immf0) -> next cycle valid_o=1,
//    data_rd=5, data_rs=7, busy[2]=1.
//  2 add r1,r2 then sub r3,r1 back-to-back -> sub held, valid_o=0, stall_o=1 until wb
//    r1=0x10; same cycle sub issues with data_rs=0x10.
//  3 immf=1, insn[11:0]=0xFFF, rs register busy -> issues, imm_ex=0xFFFFFFFF, no stall.
//  4 stall_i=1 for 3 cycles with valid_o=1 -> outputs stable, stall_o=1, busy unchanged.
//  5 hlt -> valid_o=1 for hlt, halted_o=1 next cycle, then valid_o=0, stall_o=1 for 20 cycles;
//    rst low -> halted_o=0.
//  6 Two writers to r4 (add r4; ld r4) -> ld stalls (WAW) until wb r4, then busy[4] stays 1.

Source files
------------

// File: rtl/decode.sv
// decode: instruction decode stage. Splits instruction fields, reads operands from
// the 16-entry register file (written by writeback), interlocks RAW/WAW hazards
// with a busy scoreboard and drives a registered bundle towards execute.
module decode #(
    parameter int LEN_OPECODE = 7,
    parameter int LEN_IMMF    = 1,
    parameter int LEN_REG     = 32,
    parameter int LEN_CC      = 4,
    parameter int LEN_IMM_EX  = 32,
    parameter int LEN_INSN    = 32,
    parameter int NUM_REG     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    input  logic [LEN_INSN-1:0]    insn_i,
    output logic                   stall_o,
    output logic                   valid_o,
    input  logic                   stall_i,
    output logic [LEN_OPECODE-1:0] opecode,
    output logic [LEN_IMMF-1:0]    immf,
    output logic [LEN_REG-1:0]     data_rd,
    output logic [LEN_REG-1:0]     data_rs,
    output logic [LEN_CC-1:0]      cc,
    output logic [LEN_IMM_EX-1:0]  imm_ex,
    input  logic                   wb_we_i,
    input  logic [3:0]             wb_addr_i,
    input  logic [LEN_REG-1:0]     wb_data_i,
    output logic                   halted_o
);

    localparam logic [6:0] OP_CMP = 7'b0000100;
    localparam logic [6:0] OP_LD  = 7'b0011000;
    localparam logic [6:0] OP_NOP = 7'b1111110;
    localparam logic [6:0] OP_HLT = 7'b1111111;

    // state
    logic [LEN_REG-1:0]     r_regs [NUM_REG];
    logic [NUM_REG-1:0]     r_busy;
    logic                   r_halted;
    logic                   r_valid;
    logic [LEN_OPECODE-1:0] r_opecode;
    logic [LEN_IMMF-1:0]    r_immf;
    logic [LEN_REG-1:0]     r_data_rd;
    logic [LEN_REG-1:0]     r_data_rs;
    logic [LEN_CC-1:0]      r_cc;
    logic [LEN_IMM_EX-1:0]  r_imm_ex;

    // instruction fields
    logic [6:0]            w_op;
    logic                  w_immf;
    logic [3:0]            w_rd;
    logic [3:0]            w_rs;
    logic [3:0]            w_cc;
    logic [11:0]           w_imm12;
    logic [LEN_IMM_EX-1:0] w_imm_ex;

    // classification and interlock
    logic                  w_is_nop;
    logic                  w_is_hlt;
    logic                  w_writes;
    logic                  w_reads_rd;
    logic                  w_reads_rs;
    logic [NUM_REG-1:0]    w_wb_mask;
    logic [NUM_REG-1:0]    w_rd_onehot;
    logic [NUM_REG-1:0]    w_busy_eff;
    logic                  w_hazard;
    logic                  w_issue;
    logic [LEN_REG-1:0]    w_data_rd;
    logic [LEN_REG-1:0]    w_data_rs;

    assign w_op     = insn_i[31:25];
    assign w_immf   = insn_i[24];
    assign w_rd     = insn_i[23:20];
    assign w_rs     = insn_i[19:16];
    assign w_cc     = insn_i[15:12];
    assign w_imm12  = insn_i[11:0];
    assign w_imm_ex = {{(LEN_IMM_EX-12){w_imm12[11]}}, w_imm12};

    assign w_is_nop   = (w_op == OP_NOP);
    assign w_is_hlt   = (w_op == OP_HLT);
    assign w_writes   = ((w_op[6:4] == 3'b000) && (w_op != OP_CMP))
                      || (w_op[6:3] == 4'b0010)
                      || (w_op == OP_LD);
    assign w_reads_rd = ~(w_is_nop | w_is_hlt);
    assign w_reads_rs = ~w_immf;

    // A writeback landing this cycle releases its register immediately.
    assign w_wb_mask   = wb_we_i ? (NUM_REG'(1) << wb_addr_i) : '0;
    assign w_rd_onehot = NUM_REG'(1) << w_rd;
    assign w_busy_eff  = r_busy & ~w_wb_mask;

    assign w_hazard = valid_i & ~r_halted &
                      ((w_reads_rd & w_busy_eff[w_rd]) |
                       (w_reads_rs & w_busy_eff[w_rs]) |
                       (w_writes   & w_busy_eff[w_rd]));

    assign w_issue = ~stall_i & valid_i & ~w_hazard & ~r_halted;

    // Write-first bypass so an operand written back this cycle is seen at once.
    assign w_data_rd = (wb_we_i && (wb_addr_i == w_rd)) ? wb_data_i : r_regs[w_rd];
    assign w_data_rs = (wb_we_i && (wb_addr_i == w_rs)) ? wb_data_i : r_regs[w_rs];

    assign stall_o  = (r_valid & stall_i) | w_hazard | r_halted;
    assign valid_o  = r_valid;
    assign opecode  = r_opecode;
    assign immf     = r_immf;
    assign data_rd  = r_data_rd;
    assign data_rs  = r_data_rs;
    assign cc       = r_cc;
    assign imm_ex   = r_imm_ex;
    assign halted_o = r_halted;

    // Register file: writeback writes unconditionally, regardless of stall/halt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_REG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_we_i) begin
            r_regs[wb_addr_i] <= wb_data_i;
        end
    end

    // Busy scoreboard: writeback clears first, an issuing writer then sets its rd.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_eff | ((w_issue && w_writes) ? w_rd_onehot : '0);
        end
    end

    // Output bundle: loads on issue, bubbles when not issuing, holds under stall_i.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid   <= 1'b0;
            r_opecode <= '0;
            r_immf    <= '0;
            r_data_rd <= '0;
            r_data_rs <= '0;
            r_cc      <= '0;
            r_imm_ex  <= '0;
        end else if (!stall_i) begin
            r_valid <= w_issue;
            if (w_issue) begin
                r_opecode <= LEN_OPECODE'(w_op);
                r_immf    <= LEN_IMMF'(w_immf);
                r_data_rd <= w_data_rd;
                r_data_rs <= w_data_rs;
                r_cc      <= LEN_CC'(w_cc);
                r_imm_ex  <= w_imm_ex;
            end
        end
    end

    // Halt latch: set when hlt issues, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_halted <= 1'b0;
        end else if (w_issue && w_is_hlt) begin
            r_halted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_decode.sv
// tb_decode: directed scenarios plus randomized traffic checked against a
// behavioural model of the decode stage (register values, outstanding writes, halt).
module tb_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [31:0] insn_i;
    logic        stall_o;
    logic        valid_o;
    logic        stall_i;
    logic [6:0]  opecode;
    logic [0:0]  immf;
    logic [31:0] data_rd;
    logic [31:0] data_rs;
    logic [3:0]  cc;
    logic [31:0] imm_ex;
    logic        wb_we_i;
    logic [3:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic        halted_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode #(
        .LEN_OPECODE(7),
        .LEN_REG    (32),
        .NUM_REG    (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (valid_i),
        .insn_i   (insn_i),
        .stall_o  (stall_o),
        .valid_o  (valid_o),
        .stall_i  (stall_i),
        .opecode  (opecode),
        .immf     (immf),
        .data_rd  (data_rd),
        .data_rs  (data_rs),
        .cc       (cc),
        .imm_ex   (imm_ex),
        .wb_we_i  (wb_we_i),
        .wb_addr_i(wb_addr_i),
        .wb_data_i(wb_data_i),
        .halted_o (halted_o)
    );

    // behavioural model
    logic [31:0] m_regs [16];
    logic [15:0] m_pend;
    bit          m_halted;
    bit          m_valid;
    logic [6:0]  m_op;
    logic        m_immf;
    logic [31:0] m_rd_d;
    logic [31:0] m_rs_d;
    logic [3:0]  m_cc;
    logic [31:0] m_imm;

    function automatic logic [31:0] mk(input logic [6:0] op, input logic im,
                                       input logic [3:0] rd, input logic [3:0] rs,
                                       input logic [3:0] c, input logic [11:0] imm);
        return {op, im, rd, rs, c, imm};
    endfunction

    // Register-writing instruction classes from the opcode table.
    function automatic bit f_writes(input logic [6:0] op);
        if (op == 7'h04) return 1'b0;
        if (op <= 7'h0F) return 1'b1;
        if (op >= 7'h10 && op <= 7'h18) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_hazard();
        logic [15:0] pend_now;
        logic [6:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rs;
        bit          rd_used;
        if (!valid_i || m_halted) return 1'b0;
        pend_now = m_pend;
        if (wb_we_i) pend_now[wb_addr_i] = 1'b0;
        op = insn_i[31:25];
        rd = insn_i[23:20];
        rs = insn_i[19:16];
        rd_used = !(op == 7'h7E || op == 7'h7F);
        return (rd_used && pend_now[rd]) || (!insn_i[24] && pend_now[rs]) ||
               (f_writes(op) && pend_now[rd]);
    endfunction

    function automatic bit m_stall();
        return (m_valid && stall_i) || m_hazard() || m_halted;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
        m_pend = 16'd0;
        m_halted = 1'b0;
        m_valid = 1'b0;
    endfunction

    // Advance one clock, updating the model with the inputs seen at that edge.
    task automatic tick();
        bit          hz;
        bit          iss;
        logic [31:0] ins;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [31:0] vrd;
        logic [31:0] vrs;
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic        st;
        int          v;
        ins = insn_i;
        rd  = ins[23:20];
        rs  = ins[19:16];
        we  = wb_we_i;
        wa  = wb_addr_i;
        wd  = wb_data_i;
        st  = stall_i;
        hz  = m_hazard();
        iss = !st && valid_i && !hz && !m_halted;
        vrd = (we && wa == rd) ? wd : m_regs[rd];
        vrs = (we && wa == rs) ? wd : m_regs[rs];
        @(posedge clk);
        if (we) begin
            m_regs[wa] = wd;
            m_pend[wa] = 1'b0;
        end
        if (iss) begin
            m_valid = 1'b1;
            m_op    = ins[31:25];
            m_immf  = ins[24];
            m_rd_d  = vrd;
            m_rs_d  = vrs;
            m_cc    = ins[15:12];
            v = int'(ins[11:0]);
            if (v >= 2048) v = v - 4096;
            m_imm = 32'(v);
            if (f_writes(ins[31:25])) m_pend[rd] = 1'b1;
            if (ins[31:25] == 7'h7F) m_halted = 1'b1;
        end else if (!st) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic set_idle();
        valid_i   = 1'b0;
        insn_i    = 32'd0;
        stall_i   = 1'b0;
        wb_we_i   = 1'b0;
        wb_addr_i = 4'd0;
        wb_data_i = 32'd0;
    endtask

    // Write back every outstanding register, one per cycle.
    task automatic drain();
        valid_i = 1'b0;
        stall_i = 1'b0;
        for (int r = 0; r < 16; r++) begin
            if (m_pend[r]) begin
                wb_we_i   = 1'b1;
                wb_addr_i = 4'(r);
                wb_data_i = $urandom;
                tick();
            end
        end
        wb_we_i = 1'b0;
        tick();
    endtask

    // Asynchronous reset assertion; leaves rst released at a falling edge.
    task automatic do_reset();
        rst = 1'b0;
        m_reset();
        #1;
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", valid_o);
        end
        checks++;
        if (halted_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_halted: got %b want 0", halted_o);
        end
        checks++;
        if ({opecode, immf, data_rd, data_rs, cc, imm_ex} !== '0) begin
            errors++;
            $display("FAIL reset_data: op=%h immf=%b rd=%h rs=%h cc=%h imm=%h want all 0",
                     opecode, immf, data_rd, data_rs, cc, imm_ex);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_issue: valid_o=%b want 0 while in reset", valid_o);
        end
        rst = 1'b1;
    endtask

    task automatic test_reset();
        set_idle();
        do_reset();
        valid_i = 1'b1;
        insn_i  = mk(7'h00, 1'b0, 4'd9, 4'd10, 4'd0, 12'd0);
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: got %b want 0", stall_o);
        end
        tick();
        valid_i = 1'b0;
        checks++;
        if (valid_o !== 1'b1 || data_rd !== 32'd0 || data_rs !== 32'd0) begin
            errors++;
            $display("FAIL reset_regfile: valid=%b rd=%h rs=%h want 1/0/0", valid_o, data_rd, data_rs);
        end
        drain();
    endtask

    task automatic test_basic();
        wb_we_i = 1'b1; wb_addr_i = 4'd2; wb_data_i = 32'd5;
        tick();
        wb_addr_i = 4'd3; wb_data_i = 32'd7;
        tick();
        wb_we_i = 1'b0;
        valid_i = 1'b1;
        insn_i  = mk(7'h00, 1'b0, 4'd2, 4'd3, 4'd0, 12'd0);
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_stall: got %b want 0", stall_o);
        end
        tick();
        checks++;
        if (valid_o !== 1'b1 || data_rd !== 32'd5 || data_rs !== 32'd7 || opecode !== 7'h00) begin
            errors++;
            $display("FAIL basic_issue: valid=%b rd=%h rs=%h op=%h want 1/5/7/00",
                     valid_o, data_rd, data_rs, opecode);
        end
        // a reader of r2 must now see r2 busy
        insn_i = mk(7'h01, 1'b1, 4'd2, 4'd0, 4'd0, 12'd1);
        #1;
        checks++;
        if (stall_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: stall_o=%b want 1", stall_o);
        end
        tick();
        valid_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_bubble: valid_o=%b want 0", valid_o);
        end
        drain();
    endtask

    task automatic test_raw();
        valid_i = 1'b1;
        insn_i  = mk(7'h00, 1'b0, 4'd1, 4'd2, 4'd0, 12'd0);
        tick();
        insn_i  = mk(7'h01, 1'b0, 4'd3, 4'd1, 4'd0, 12'd0);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (stall_o !== 1'b1) begin
                errors++;
                $display("FAIL raw_stall[%0d]: got %b want 1", k, stall_o);
            end
            tick();
            checks++;
            if (valid_o !== 1'b0) begin
                errors++;
                $display("FAIL raw_hold[%0d]: valid_o=%b want 0", k, valid_o);
            end
        end
        wb_we_i = 1'b1; wb_addr_i = 4'd1; wb_data_i = 32'h10;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL raw_release: stall_o=%b want 0", stall_o);
        end
        tick();
        wb_we_i = 1'b0;
        valid_i = 1'b0;
        checks++;
        if (valid_o !== 1'b1 || data_rs !== 32'h10 || data_rd !== 32'd7 || opecode !== 7'h01) begin
            errors++;
            $display("FAIL raw_issue: valid=%b rs=%h rd=%h op=%h want 1/10/7/01",
                     valid_o, data_rs, data_rd, opecode);
        end
        drain();
    endtask

    task automatic test_imm();
        valid_i = 1'b1;
        insn_i  = mk(7'h00, 1'b0, 4'd5, 4'd0, 4'd0, 12'd0);
        tick();
        insn_i  = mk(7'h02, 1'b1, 4'd6, 4'd5, 4'hA, 12'hFFF);
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL imm_stall: got %b want 0 (rs busy but unused)", stall_o);
        end
        tick();
        checks++;
        if (valid_o !== 1'b1 || imm_ex !== 32'hFFFF_FFFF || immf !== 1'b1 ||
            cc !== 4'hA || opecode !== 7'h02) begin
            errors++;
            $display("FAIL imm_issue: valid=%b imm=%h immf=%b cc=%h op=%h want 1/ffffffff/1/a/02",
                     valid_o, imm_ex, immf, cc, opecode);
        end
    endtask

    task automatic test_stall();
        stall_i = 1'b1;
        valid_i = 1'b1;
        insn_i  = mk(7'h00, 1'b0, 4'd7, 4'd8, 4'd3, 12'h123);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (stall_o !== 1'b1) begin
                errors++;
                $display("FAIL stall_o[%0d]: got %b want 1", k, stall_o);
            end
            tick();
            checks++;
            if (valid_o !== 1'b1 || imm_ex !== 32'hFFFF_FFFF || cc !== 4'hA || opecode !== 7'h02) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b imm=%h cc=%h op=%h want 1/ffffffff/a/02",
                         k, valid_o, imm_ex, cc, opecode);
            end
        end
        stall_i = 1'b0;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: got %b want 0", stall_o);
        end
        tick();
        valid_i = 1'b0;
        checks++;
        if (valid_o !== 1'b1 || imm_ex !== 32'h123 || data_rd !== m_rd_d || data_rs !== m_rs_d) begin
            errors++;
            $display("FAIL stall_issue: valid=%b imm=%h rd=%h rs=%h want 1/123/%h/%h",
                     valid_o, imm_ex, data_rd, data_rs, m_rd_d, m_rs_d);
        end
        drain();
    endtask

    task automatic test_waw();
        valid_i = 1'b1;
        insn_i  = mk(7'h00, 1'b0, 4'd4, 4'd0, 4'd0, 12'd0);
        tick();
        insn_i  = mk(7'h18, 1'b1, 4'd4, 4'd0, 4'd0, 12'h010);
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (stall_o !== 1'b1) begin
                errors++;
                $display("FAIL waw_stall[%0d]: got %b want 1", k, stall_o);
            end
            tick();
        end
        wb_we_i = 1'b1; wb_addr_i = 4'd4; wb_data_i = 32'hCAFE_0004;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL waw_release: got %b want 0", stall_o);
        end
        tick();
        wb_we_i = 1'b0;
        checks++;
        if (valid_o !== 1'b1 || opecode !== 7'h18 || data_rd !== 32'hCAFE_0004) begin
            errors++;
            $display("FAIL waw_issue: valid=%b op=%h rd=%h want 1/18/cafe0004", valid_o, opecode, data_rd);
        end
        // st reads r4: the ld keeps r4 busy even though the old write retired
        insn_i = mk(7'h19, 1'b1, 4'd4, 4'd0, 4'd0, 12'd0);
        #1;
        checks++;
        if (stall_o !== 1'b1) begin
            errors++;
            $display("FAIL waw_busy_kept: stall_o=%b want 1", stall_o);
        end
        tick();
        valid_i = 1'b0;
        drain();
    endtask

    task automatic test_random();
        logic [6:0] ops [11];
        bit         take_new;
        int         start;
        int         idx;
        ops = '{7'h00, 7'h01, 7'h04, 7'h08, 7'h0F, 7'h18, 7'h19, 7'h1A, 7'h1B, 7'h7E, 7'h30};
        take_new = 1'b1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (take_new) begin
                valid_i = ($urandom_range(0, 3) != 0);
                insn_i  = mk(ops[$urandom_range(0, 10)], 1'($urandom_range(0, 1)),
                             4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                             4'($urandom), 12'($urandom));
            end
            stall_i = ($urandom_range(0, 3) == 0);
            wb_we_i = 1'b0;
            if (m_pend != 16'd0 && $urandom_range(0, 1) == 1) begin
                start = $urandom_range(0, 15);
                idx = -1;
                for (int k = 0; k < 16; k++) begin
                    if (idx < 0 && m_pend[(start + k) % 16]) idx = (start + k) % 16;
                end
                wb_we_i   = 1'b1;
                wb_addr_i = 4'(idx);
            end else if ($urandom_range(0, 9) == 0) begin
                wb_we_i   = 1'b1;
                wb_addr_i = 4'($urandom);
            end
            wb_data_i = $urandom;
            #1;
            take_new = !(valid_i && m_stall());
            checks++;
            if (stall_o !== m_stall()) begin
                errors++;
                $display("FAIL rand_stall[%0d]: got %b want %b", cyc, stall_o, m_stall());
            end
            tick();
            checks++;
            if (valid_o !== m_valid || halted_o !== 1'b0) begin
                errors++;
                $display("FAIL rand_valid[%0d]: valid=%b halted=%b want %b/0", cyc, valid_o, halted_o, m_valid);
            end
            if (m_valid) begin
                checks++;
                if (opecode !== m_op || immf !== m_immf || data_rd !== m_rd_d ||
                    data_rs !== m_rs_d || cc !== m_cc || imm_ex !== m_imm) begin
                    errors++;
                    $display("FAIL rand_bundle[%0d]: got op=%h immf=%b rd=%h rs=%h cc=%h imm=%h want op=%h immf=%b rd=%h rs=%h cc=%h imm=%h",
                             cyc, opecode, immf, data_rd, data_rs, cc, imm_ex,
                             m_op, m_immf, m_rd_d, m_rs_d, m_cc, m_imm);
                end
            end
        end
        set_idle();
        drain();
    endtask

    task automatic test_halt();
        valid_i = 1'b1;
        insn_i  = mk(7'h7F, 1'b0, 4'd0, 4'd0, 4'd0, 12'd0);
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL halt_accept: stall_o=%b want 0", stall_o);
        end
        tick();
        checks++;
        if (valid_o !== 1'b1 || opecode !== 7'h7F || halted_o !== 1'b1) begin
            errors++;
            $display("FAIL halt_issue: valid=%b op=%h halted=%b want 1/7f/1", valid_o, opecode, halted_o);
        end
        insn_i = mk(7'h00, 1'b1, 4'd11, 4'd0, 4'd0, 12'd0);
        for (int k = 0; k < 20; k++) begin
            #1;
            checks++;
            if (stall_o !== 1'b1) begin
                errors++;
                $display("FAIL halt_stall[%0d]: got %b want 1", k, stall_o);
            end
            tick();
            checks++;
            if (valid_o !== 1'b0 || halted_o !== 1'b1) begin
                errors++;
                $display("FAIL halt_bubble[%0d]: valid=%b halted=%b want 0/1", k, valid_o, halted_o);
            end
        end
        do_reset();
        valid_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        valid_i = 1'b1;
        insn_i  = mk(7'h00, 1'b0, 4'd4, 4'd0, 4'd0, 12'd0);
        tick();
        insn_i  = mk(7'h01, 1'b0, 4'd3, 4'd4, 4'd0, 12'd0);
        #1;
        checks++;
        if (stall_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_hazard: stall_o=%b want 1", stall_o);
        end
        do_reset();
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_cleared: stall_o=%b want 0", stall_o);
        end
        tick();
        valid_i = 1'b0;
        checks++;
        if (valid_o !== 1'b1 || data_rd !== 32'd0 || data_rs !== 32'd0) begin
            errors++;
            $display("FAIL mid_issue: valid=%b rd=%h rs=%h want 1/0/0", valid_o, data_rd, data_rs);
        end
    endtask

    initial begin
        rst = 1'b0;
        set_idle();
        m_reset();
        test_reset();
        test_basic();
        test_raw();
        test_imm();
        test_stall();
        test_waw();
        test_random();
        test_halt();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

endmodule
